mult_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one start/done multiplier between NREQ requesters. It accepts an operand pair from one requester at a time and drives the multiplier's a/b/start, holding operands stable until done. It returns the product to the granted requester. It sits between client blocks and a single shared multiplier instance.

---
 rtl/mult_share_arbiter.sv | 152 +++++++++++++++
 tb/tb_mult_share_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter and sequencer sharing one start/done multiplier among NREQ requesters.
// Build option: define MULT_ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles.
module mult_share_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic [NREQ-1:0]           resp_valid,
    output logic [2*WIDTH-1:0]        resp_product,
    output logic                      resp_err,
    output logic [WIDTH-1:0]          mul_a,
    output logic [WIDTH-1:0]          mul_b,
    output logic                      mul_start,
    input  logic [2*WIDTH-1:0]        mul_product,
    input  logic                      mul_done,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    // state | meaning
    // IDLE  | no operation; grant the next valid requester round-robin
    // ISSUE | one-cycle mul_start pulse with latched operands
    // WAIT  | wait for a fresh (armed) mul_done
    // RESP  | one-cycle resp_valid to the granted requester
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int GW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_illegal_params
    end

    state_t            state, state_nx;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     pick;
    logic              found;
    logic [WIDTH-1:0]  op_a, op_b;
    logic              armed;
    logic              tmo;
    logic [WIDTH-1:0]  a_arr [NREQ];
    logic [WIDTH-1:0]  b_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = req_a[i*WIDTH +: WIDTH];
            b_arr[i] = req_b[i*WIDTH +: WIDTH];
        end
    end

    // Search starts just after the last served requester so nobody starves.
    always_comb begin
        int idx;
        logic [GW-1:0] sel;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            sel = idx[GW-1:0];
            if (!found && req_valid[sel]) begin
                found = 1'b1;
                pick  = sel;
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          err_q;

    assign tmo      = (cnt == '0);
    assign resp_err = (state == RESP) && err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (state == ISSUE) begin
            cnt   <= CW'(TIMEOUT - 1);
            err_q <= 1'b0;
        end else if (state == WAIT) begin
            if (!(armed && mul_done) && tmo) err_q <= 1'b1;
            if (cnt != '0) cnt <= cnt - CW'(1);
        end
    end
`else
    assign tmo      = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if ((armed && mul_done) || tmo) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant   <= GW'(NREQ - 1);
            grant_id     <= '0;
            op_a         <= '0;
            op_b         <= '0;
            resp_product <= '0;
            armed        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= pick;
                        op_a     <= a_arr[pick];
                        op_b     <= b_arr[pick];
                    end
                end
                ISSUE: armed <= 1'b0;
                WAIT: begin
                    // A done left high by the previous op only counts after it has dropped.
                    if (!mul_done) armed <= 1'b1;
                    if (armed && mul_done) resp_product <= mul_product;
                    else if (tmo)          resp_product <= '0;
                end
                RESP: last_grant <= grant_id;
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == IDLE && found && !rst) ? (NREQ'(1) << pick) : '0;
    assign resp_valid = (state == RESP) ? (NREQ'(1) << grant_id) : '0;
    assign mul_start  = (state == ISSUE);
    assign busy       = (state != IDLE);
    assign mul_a      = op_a;
    assign mul_b      = op_b;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: directed scenarios plus randomized traffic,
// with a behavioural start/done multiplier model driving mul_done/mul_product.
module tb_mult_share_arbiter;
    localparam int WIDTH   = 16;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 15;
    localparam int GW      = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [NREQ-1:0]       req_ready, resp_valid;
    logic [2*WIDTH-1:0]    resp_product;
    logic                  resp_err;
    logic [WIDTH-1:0]      mul_a, mul_b;
    logic                  mul_start;
    logic [2*WIDTH-1:0]    mul_product = '0;
    logic                  mul_done = 1'b0;
    logic                  busy;
    logic [GW-1:0]         grant_id;

    logic [WIDTH-1:0] opa [NREQ];
    logic [WIDTH-1:0] opb [NREQ];
    logic [NREQ-1:0]  hold_mask = '0;
    int  lat_lo = 1, lat_hi = 3, stale_cfg = 0;
    bit  never_done = 1'b0;

    for (genvar i = 0; i < NREQ; i++) begin : g_pack
        assign req_a[i*WIDTH +: WIDTH] = opa[i];
        assign req_b[i*WIDTH +: WIDTH] = opb[i];
    end

    mult_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_product(resp_product),
        .resp_err(resp_err), .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_product(mul_product), .mul_done(mul_done), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: done may stay high for stale_cfg cycles after start, then drops, then rises with the product.
    int sl = 0, rem = 0;
    bit run = 1'b0;
    logic [2*WIDTH-1:0] pa;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_done <= 1'b0;
            run = 1'b0; sl = 0; rem = 0;
        end else if (mul_start) begin
            pa  = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);
            sl  = stale_cfg;
            rem = stale_cfg + int'($urandom_range(lat_hi, lat_lo));
            run = 1'b1;
            if (sl == 0) mul_done <= 1'b0;
        end else if (run) begin
            if (sl > 0) begin
                sl = sl - 1;
                if (sl == 0) mul_done <= 1'b0;
            end
            rem = rem - 1;
            if (rem == 0) begin
                run = 1'b0;
                if (!never_done) begin
                    mul_done    <= 1'b1;
                    mul_product <= pa;
                end
            end
        end
    end

    typedef struct {
        int                 g;
        logic [2*WIDTH-1:0] p;
        bit                 e;
    } exp_t;

    exp_t exp_q[$];
    int   glog[$];
    int   errors = 0, checks = 0;
    int   last_m = NREQ - 1;
    bit   pend_start = 1'b0;
    logic [WIDTH-1:0] cur_a = '0, cur_b = '0;
    int   n_acc = 0, n_start = 0, n_resp = 0, t_start = 0, t_resp = 0;
    logic [2*WIDTH-1:0] last_prod = '0;
    bit   last_err = 1'b0;

    string       d_name;
    logic [63:0] d_act, d_exp;
    int          d_req = 0, d_ack = 0;

    function automatic int next_rr(int last, logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    task automatic check(string name, bit ok, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: sole owner of the check counters and of the reference model state.
    always @(negedge clk) begin
        bit idle_m;
        int g;
        logic [NREQ-1:0] exp_rdy;
        exp_t e;
        if (d_req != d_ack) begin
            check(d_name, d_act == d_exp, d_act, d_exp);
            d_ack = d_req;
        end
        if (rst) begin
            check("rst_ctrl", {req_ready, resp_valid, resp_err, mul_start, busy, grant_id} == '0,
                  64'({req_ready, resp_valid, resp_err, mul_start, busy, grant_id}), 64'd0);
            check("rst_data", {resp_product, mul_a, mul_b} == 64'd0, {resp_product, mul_a, mul_b}, 64'd0);
            last_m = NREQ - 1;
            exp_q.delete();
            pend_start = 1'b0;
        end else begin
            idle_m = (exp_q.size() == 0);
            check("busy", busy == !idle_m, 64'(busy), 64'(!idle_m));
            exp_rdy = '0;
            g = -1;
            if (idle_m && req_valid != '0) begin
                g = next_rr(last_m, req_valid);
                exp_rdy = NREQ'(1) << g;
            end
            check("req_ready", req_ready == exp_rdy, 64'(req_ready), 64'(exp_rdy));
            if (g >= 0) begin
                e.g = g;
`ifdef MULT_ARB_TIMEOUT_EN
                e.e = never_done;
`else
                e.e = 1'b0;
`endif
                e.p = e.e ? '0 : (2*WIDTH)'(opa[g]) * (2*WIDTH)'(opb[g]);
                exp_q.push_back(e);
                cur_a = opa[g];
                cur_b = opb[g];
                pend_start = 1'b1;
                last_m = g;
                glog.push_back(g);
                n_acc++;
            end
            if (mul_start) begin
                check("start_expected", pend_start, 64'(mul_start), 64'(pend_start));
                check("start_operands", mul_a == cur_a && mul_b == cur_b, {32'd0, mul_a, mul_b}, {32'd0, cur_a, cur_b});
                pend_start = 1'b0;
                n_start++;
                t_start = cyc;
            end else if (!idle_m) begin
                check("operands_held", mul_a == cur_a && mul_b == cur_b, {32'd0, mul_a, mul_b}, {32'd0, cur_a, cur_b});
            end
            if (resp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 1'b0, 64'(resp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_valid", resp_valid == (NREQ'(1) << e.g), 64'(resp_valid), 64'(NREQ'(1) << e.g));
                    check("resp_product", resp_product == e.p, 64'(resp_product), 64'(e.p));
                    check("resp_err", resp_err == e.e, 64'(resp_err), 64'(e.e));
                    check("grant_id", int'(grant_id) == e.g, 64'(grant_id), 64'(e.g));
                end
                n_resp++;
                t_resp = cyc;
                last_prod = resp_product;
                last_err = resp_err;
            end
        end
    end

    task automatic post(string n, logic [63:0] a, logic [63:0] e);
        d_name = n; d_act = a; d_exp = e;
        d_req++;
        @(posedge clk); #2;
    endtask

    task automatic tick();
        logic [NREQ-1:0] snap;
        @(negedge clk);
        snap = req_ready;
        @(posedge clk); #2;
        req_valid = (req_valid & ~snap) | hold_mask;
    endtask

    function automatic logic [WIDTH-1:0] rnd_op();
        case ($urandom_range(3))
            0: return '0;
            1: return '1;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    task automatic drain(int budget);
        int c = 0;
        while ((req_valid != '0 || busy || exp_q.size() != 0) && c < budget) begin
            tick();
            c++;
        end
        post("drain_idle", {61'd0, busy, req_valid != '0, exp_q.size() != 0}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int base, ns, nr, a0, c;
        bit seen0;
        for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // 1: single request
        base = glog.size(); ns = n_start;
        opa[0] = 3; opb[0] = 5; req_valid = 4'b0001;
        drain(200);
        post("t1_grants", glog.size() - base, 1);
        post("t1_starts", n_start - ns, 1);
        post("t1_product", last_prod, 15);

        // 2: all four from reset -> 0,1,2,3
        do_reset();
        base = glog.size(); ns = n_start;
        for (int i = 0; i < NREQ; i++) begin opa[i] = WIDTH'(i + 1); opb[i] = 10; end
        req_valid = '1;
        drain(400);
        for (int i = 0; i < NREQ; i++) post("t2_order", glog[base + i], i);
        post("t2_starts", n_start - ns, 4);
        post("t2_last_product", last_prod, 40);

        // 3: 1 and 3 held, then 0 joins
        base = glog.size();
        hold_mask = 4'b1010;
        req_valid = hold_mask;
        c = 0;
        while (glog.size() < base + 4 && c < 400) begin tick(); c++; end
        opa[0] = 7; opb[0] = 9; req_valid[0] = 1'b1;
        while (glog.size() < base + 6 && c < 800) begin tick(); c++; end
        hold_mask = '0;
        drain(400);
        post("t3_g0", glog[base], 1);
        post("t3_g1", glog[base + 1], 3);
        post("t3_g2", glog[base + 2], 1);
        post("t3_g3", glog[base + 3], 3);
        seen0 = (glog[base + 4] == 0) || (glog[base + 5] == 0);
        post("t3_req0_served", 64'(seen0), 1);

        // 4: full-scale operands with stale done at ISSUE
        stale_cfg = 3;
        opa[2] = '1; opb[2] = '1; req_valid = 4'b0100;
        drain(200);
        post("t4_product", last_prod, 64'hFFFE_0001);
        stale_cfg = 0;

        // 5: reset during WAIT
        lat_lo = 20; lat_hi = 20;
        ns = n_start;
        opa[0] = 11; opb[0] = 13; req_valid = 4'b0001;
        c = 0;
        while (n_start == ns && c < 50) begin tick(); c++; end
        tick(); tick(); tick();
        nr = n_resp;
        do_reset();
        lat_lo = 1; lat_hi = 3;
        base = glog.size();
        opa[1] = 6; opb[1] = 7; opa[3] = 8; opb[3] = 9;
        req_valid = 4'b1010;
        drain(400);
        post("t5_first_grant", glog[base], 1);
        post("t5_resp_count", n_resp - nr, 2);

        // 6: multiplier never completes
        never_done = 1'b1;
        nr = n_resp; ns = n_start;
        opa[0] = 2; opb[0] = 2; req_valid = 4'b0001;
`ifdef MULT_ARB_TIMEOUT_EN
        drain(300);
        post("t6_latency", t_resp - t_start, TIMEOUT + 1);
        post("t6_err", 64'(last_err), 1);
        post("t6_product", last_prod, 0);
        never_done = 1'b0;
`else
        c = 0;
        while (n_start == ns && c < 50) begin tick(); c++; end
        repeat (100) tick();
        post("t6_busy", 64'(busy), 1);
        post("t6_no_resp", n_resp - nr, 0);
        never_done = 1'b0;
        do_reset();
`endif

        // random traffic
        a0 = n_acc; nr = n_resp;
        lat_lo = 1; lat_hi = 6;
        for (int t = 0; t < 600; t++) begin
            stale_cfg = $urandom_range(2);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(3) == 0) begin
                    opa[i] = rnd_op();
                    opb[i] = rnd_op();
                    req_valid[i] = 1'b1;
                end
            end
            tick();
        end
        drain(1000);
        post("rand_all_served", n_resp - nr, n_acc - a0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
